// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops with JK, count-up, count-down and shift-left modes.
// Define JK_SAT_EN to make the count modes saturate at their limits instead of wrapping.
module jk_register_bank #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] down_next;

  // Values above MAX_COUNT are reachable via JK/shift; up folds them to 0, down to MAX_COUNT.
  always_comb begin
    up_next = '0;
    if (q < MAX_Q) begin
      up_next = q + 1'b1;
    end else if (q == MAX_Q) begin
`ifdef JK_SAT_EN
      up_next = MAX_Q;
`else
      up_next = '0;
`endif
    end
  end

  always_comb begin
    down_next = q - 1'b1;
    if (q > MAX_Q) begin
      down_next = MAX_Q;
    end else if (q == '0) begin
`ifdef JK_SAT_EN
      down_next = '0;
`else
      down_next = MAX_Q;
`endif
    end
  end

  always_comb begin
    q_next = q;
    unique case (mode)
      MODE_JK: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          unique case ({j[i], k[i]})
            2'b00: q_next[i] = q[i];
            2'b01: q_next[i] = 1'b0;
            2'b10: q_next[i] = 1'b1;
            2'b11: q_next[i] = ~q[i];
          endcase
        end
      end
      MODE_UP:    q_next = up_next;
      MODE_DOWN:  q_next = down_next;
      MODE_SHIFT: q_next = {q[WIDTH-2:0], sin};
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (pr) begin
      q <= MAX_Q;
    end else if (en) begin
      q <= q_next;
    end
  end

  assign qn = ~q;
  assign tc = ((mode == MODE_UP) && (q == MAX_Q)) || ((mode == MODE_DOWN) && (q == '0));

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed, table-driven check of jk_register_bank with WIDTH=4, MAX_COUNT=9.
module tb_jk_register_bank;

  localparam int unsigned W = 4;
`ifdef JK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         pr  = 1'b0;
  logic         en  = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic         sin = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;

  int errors = 0;
  int checks = 0;

  jk_register_bank #(.WIDTH(W), .MAX_COUNT(9)) dut (
    .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode),
    .j(j), .k(k), .sin(sin), .q(q), .qn(qn), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         pr;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         sin;
    logic [W-1:0] eq;
    logic         etc;
    string        name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic p, input logic e, input logic [1:0] m,
                              input logic [W-1:0] jj, input logic [W-1:0] kk, input logic s,
                              input logic [W-1:0] eq, input logic etc, input string name);
    vec_t v;
    v.clr = c; v.pr = p; v.en = e; v.mode = m; v.j = jj; v.k = kk; v.sin = s;
    v.eq = eq; v.etc = etc; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    clr = v.clr; pr = v.pr; en = v.en; mode = v.mode; j = v.j; k = v.k; sin = v.sin;
    @(posedge clk);
    #1;
    checks++;
    if (q !== v.eq) begin
      errors++;
      $display("FAIL %s q: got %b expected %b", v.name, q, v.eq);
    end
    checks++;
    if (qn !== ~v.eq) begin
      errors++;
      $display("FAIL %s qn: got %b expected %b", v.name, qn, ~v.eq);
    end
    checks++;
    if (tc !== v.etc) begin
      errors++;
      $display("FAIL %s tc: got %b expected %b", v.name, tc, v.etc);
    end
  endtask

  task automatic step(input logic c, input logic p, input logic e, input logic [1:0] m,
                      input logic [W-1:0] eq, input logic etc, input string name);
    vec_t v;
    v.clr = c; v.pr = p; v.en = e; v.mode = m; v.j = '0; v.k = '0; v.sin = 1'b0;
    v.eq = eq; v.etc = etc; v.name = name;
    apply(v);
  endtask

  initial begin
    logic [W-1:0] e;

    // Reset, preset, and clr-over-pr priority.
    add(1, 0, 1, 2'b00, 4'h0, 4'h0, 0, 4'b0000, 0, "clr");
    add(0, 1, 1, 2'b00, 4'h0, 4'h0, 0, 4'b1001, 0, "preset");
    add(1, 1, 1, 2'b00, 4'h0, 4'h0, 0, 4'b0000, 0, "clr_over_pr");
    // JK mode.
    add(0, 0, 1, 2'b00, 4'b1010, 4'b0000, 0, 4'b1010, 0, "jk_set");
    add(0, 0, 1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0101, 0, "jk_toggle");
    add(0, 0, 1, 2'b00, 4'b0000, 4'b0100, 0, 4'b0001, 0, "jk_reset");
    add(0, 0, 0, 2'b00, 4'b1111, 4'b0000, 0, 4'b0001, 0, "jk_hold_en0");
    // Count up from 0 across the limit.
    add(1, 0, 1, 2'b01, 4'h0, 4'h0, 0, 4'b0000, 0, "up_clr");
    for (int i = 1; i <= 10; i++) begin
      e = (i <= 9) ? W'(i) : (SAT ? 4'd9 : 4'd0);
      add(0, 0, 1, 2'b01, 4'h0, 4'h0, 0, e, e == 4'd9, $sformatf("up_%0d", i));
    end
    // Count down from 0 across the limit.
    add(1, 0, 1, 2'b10, 4'h0, 4'h0, 0, 4'b0000, 1, "down_clr");
    add(0, 0, 1, 2'b10, 4'h0, 4'h0, 0, SAT ? 4'd0 : 4'd9, SAT, "down_1");
    add(0, 0, 1, 2'b10, 4'h0, 4'h0, 0, SAT ? 4'd0 : 4'd8, SAT, "down_2");
    // Out-of-range values folded back by the counters.
    add(0, 0, 1, 2'b00, 4'b1111, 4'b0000, 0, 4'b1111, 0, "force_f");
    add(0, 0, 1, 2'b10, 4'h0, 4'h0, 0, 4'b1001, 0, "down_from_f");
    add(0, 0, 1, 2'b10, 4'h0, 4'h0, 0, 4'b1000, 0, "down_after_f");
    add(0, 0, 1, 2'b00, 4'b1111, 4'b0000, 0, 4'b1111, 0, "force_f2");
    add(0, 0, 1, 2'b01, 4'h0, 4'h0, 0, 4'b0000, 0, "up_from_f");
    // Shift left.
    add(1, 0, 1, 2'b11, 4'h0, 4'h0, 0, 4'b0000, 0, "shift_clr");
    add(0, 0, 1, 2'b11, 4'h0, 4'h0, 1, 4'b0001, 0, "shift_1");
    add(0, 0, 1, 2'b11, 4'h0, 4'h0, 0, 4'b0010, 0, "shift_2");
    add(0, 0, 1, 2'b11, 4'h0, 4'h0, 1, 4'b0101, 0, "shift_3");
    add(0, 0, 1, 2'b11, 4'h0, 4'h0, 1, 4'b1011, 0, "shift_4");
    add(0, 0, 1, 2'b11, 4'h0, 4'h0, 1, 4'b0111, 0, "shift_5");

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Clear mid-count, then counting resumes from 0.
    step(1, 0, 1, 2'b01, 4'd0, 0, "mid_clr0");
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 2'b01, W'(i), 0, "mid_up");
    step(1, 0, 1, 2'b01, 4'd0, 0, "mid_clr");
    step(0, 0, 1, 2'b01, 4'd1, 0, "mid_resume");
    // Preset mid-count lands on the limit.
    step(0, 1, 1, 2'b01, 4'd9, 1, "mid_preset");
    // Hold at the limit with en=0: tc stays up.
    step(0, 0, 0, 2'b01, 4'd9, 1, "hold9_a");
    step(0, 0, 0, 2'b01, 4'd9, 1, "hold9_b");
    // tc follows mode combinationally while held.
    step(0, 0, 0, 2'b10, 4'd9, 0, "hold9_down");
    step(0, 0, 1, 2'b10, 4'd8, 0, "down_from9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
